// File: rtl/hdmi_packet_serializer.sv
// Serializes one HDMI data-island packet (header + four subpackets) into 9-bit words over 32 pixels,
// appending BCH parity computed on the fly, and paces the upstream packet picker.
module hdmi_packet_serializer #(
  parameter logic [7:0] BCH_POLY = 8'b1000_0011
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               data_island_period,
  input  logic [23:0]        header,
  input  logic [3:0][55:0]   sub,
  output logic [4:0]         packet_pixel_counter,
  output logic               packet_enable,
  output logic [8:0]         packet_data
);

  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

  logic [4:0]       counter_q, counter_d;
  logic [7:0]       ecc_hdr_q, ecc_hdr_d;
  logic [3:0][7:0]  ecc_sub_q, ecc_sub_d;
  logic [31:0]      hdr_stream;
  logic [3:0][63:0] sub_stream;
  logic [3:0]       even_bit, odd_bit;
  logic             hdr_bit;
  logic             active;
  logic             last_pixel;
  logic [5:0]       even_idx, odd_idx;

  assign active     = data_island_period && !reset;
  assign last_pixel = (counter_q == 5'd31);
  assign even_idx   = {counter_q, 1'b0};
  assign odd_idx    = {counter_q, 1'b1};

  // Parity sits directly above the payload, so one index walks payload then parity.
  assign hdr_stream = {ecc_hdr_q, header};
  assign hdr_bit    = hdr_stream[counter_q];

  assign counter_d = data_island_period ? counter_q + 5'd1 : 5'd0;

  always_comb begin
    ecc_hdr_d = ecc_hdr_q;
    if (!data_island_period || last_pixel) begin
      ecc_hdr_d = 8'h00;
    end else if (counter_q < 5'd24) begin
      ecc_hdr_d = bch_step(ecc_hdr_q, hdr_bit);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_stream[gi] = {ecc_sub_q[gi], sub[gi]};
      assign even_bit[gi]   = sub_stream[gi][even_idx];
      assign odd_bit[gi]    = sub_stream[gi][odd_idx];
      // Two payload bits are absorbed per pixel, even bit first.
      assign ecc_sub_d[gi]  = (!data_island_period || last_pixel) ? 8'h00 :
                              (counter_q < 5'd28) ?
                                bch_step(bch_step(ecc_sub_q[gi], even_bit[gi]), odd_bit[gi]) :
                                ecc_sub_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter_q <= 5'd0;
      ecc_hdr_q <= 8'h00;
      ecc_sub_q <= '0;
    end else begin
      counter_q <= counter_d;
      ecc_hdr_q <= ecc_hdr_d;
      ecc_sub_q <= ecc_sub_d;
    end
  end

  assign packet_pixel_counter = counter_q;
  assign packet_enable        = active && last_pixel;
  assign packet_data          = active ? {odd_bit, even_bit, hdr_bit} : 9'h000;

endmodule

// File: tb/tb_hdmi_packet_serializer.sv
// Randomized scoreboard bench for hdmi_packet_serializer against a bit-serial BCH reference model.
module tb_hdmi_packet_serializer;

  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [4:0]       packet_pixel_counter;
  logic             packet_enable;
  logic [8:0]       packet_data;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_serializer dut (
    .clk_pixel            (clk_pixel),
    .reset                (reset),
    .data_island_period   (data_island_period),
    .header               (header),
    .sub                  (sub),
    .packet_pixel_counter (packet_pixel_counter),
    .packet_enable        (packet_enable),
    .packet_data          (packet_data)
  );

  typedef struct {
    bit         chk_k;
    logic [4:0] k;
    logic       en;
    logic [8:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_k  = 0;

  // BCH parity of the first n bits of v, bit 0 first, G(x)=1+x^6+x^7+x^8 in reflected form.
  function automatic logic [7:0] bch(input logic [55:0] v, input int n);
    logic [7:0] e = 8'h00;
    for (int j = 0; j < n; j++)
      e = (e >> 1) ^ ((e[0] ^ v[j]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  function automatic logic [8:0] ref_word(input int k);
    logic [8:0]  w;
    logic [7:0]  hp, sp;
    logic [55:0] hv;
    hv = {32'h0, header};
    hp = bch(hv, 24);
    w  = '0;
    w[0] = (k < 24) ? header[k] : hp[k-24];
    for (int i = 0; i < 4; i++) begin
      sp = bch(sub[i], 56);
      w[1+i] = (k < 28) ? sub[i][2*k]   : sp[2*(k-28)];
      w[5+i] = (k < 28) ? sub[i][2*k+1] : sp[2*(k-28)+1];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // One pixel: drive controls, record what the DUT must show this cycle, advance.
  task automatic cycle(input bit rst, input bit isl);
    exp_t e;
    reset = rst;
    data_island_period = isl;
    e.chk_k = !rst;
    e.k     = 5'(model_k);
    e.en    = isl && !rst && (model_k == 31);
    e.data  = (isl && !rst) ? ref_word(model_k) : 9'h000;
    sb_q.push_back(e);
    model_k = rst ? 0 : (isl ? (model_k + 1) % 32 : 0);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic randomize_packet();
    logic [63:0] r;
    header = 24'($urandom());
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      sub[i] = r[55:0];
    end
  endtask

  task automatic island(input int n, input string tag);
    $display("packet %s: header=%h sub3..0=%h_%h_%h_%h pixels=%0d",
             tag, header, sub[3], sub[2], sub[1], sub[0], n);
    repeat (n) cycle(1'b0, 1'b1);
  endtask

  always @(negedge clk_pixel) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("packet_data", packet_data, e.data);
      check("packet_enable", {8'h0, packet_enable}, {8'h0, e.en});
      if (e.chk_k) check("packet_pixel_counter", {4'h0, packet_pixel_counter}, {4'h0, e.k});
    end
  end

  initial begin
    reset = 1'b1;
    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    @(posedge clk_pixel);
    #1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    island(32, "zeros");
    header = 24'h800000;
    island(32, "hdr_msb");
    header = '0;
    sub[0] = 56'h80_0000_0000_0000;
    island(32, "sub0_msb");
    repeat (3) cycle(1'b0, 1'b0);

    for (int p = 0; p < 8; p++) begin
      randomize_packet();
      island(32, "random");
    end
    repeat (2) cycle(1'b0, 1'b0);

    randomize_packet();
    island(13, "reset_abort");
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    randomize_packet();
    island(32, "after_reset");

    randomize_packet();
    island(20, "drop_at_20");
    repeat (5) cycle(1'b0, 1'b0);
    island(32, "restart");
    repeat (2) cycle(1'b0, 1'b0);

    @(negedge clk_pixel);
    #1;
    check("scoreboard_drained", 9'(sb_q.size()), 9'h000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
